// File: rtl/register_list_sequencer.sv
// Load/store-multiple register list sequencer: walks a 16-bit register list in
// ascending order, issuing one (register, word address) transfer per accepted cycle.
module register_list_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           reg_list,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  ready,
  output logic                  busy,
  output logic                  valid,
  output logic [3:0]            reg_num,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  first,
  output logic                  last,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] wb_addr
);

  localparam int unsigned LIST_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned IDX_W  = 4;

  localparam logic [1:0] MODE_IA = 2'd0;
  localparam logic [1:0] MODE_IB = 2'd1;
  localparam logic [1:0] MODE_DA = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t                r_state, w_state;
  logic [LIST_W-1:0]     r_pending, w_pending;
  logic                  r_busy, w_busy;
  logic                  r_valid, w_valid;
  logic [IDX_W-1:0]      r_reg_num, w_reg_num;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic                  r_first, w_first;
  logic                  r_last, w_last;
  logic                  r_done, w_done;
  logic [ADDR_WIDTH-1:0] r_wb_addr, w_wb_addr;

  logic [CNT_W-1:0]      w_cnt;
  logic [ADDR_WIDTH-1:0] w_span;
  logic [LIST_W-1:0]     w_pend_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [LIST_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LIST_W; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Isolate the lowest set bit, then one-hot encode it to an index.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [LIST_W-1:0] v);
    logic [LIST_W-1:0] iso;
    logic [IDX_W-1:0]  idx;
    iso = v & (~v + LIST_W'(1));
    idx = '0;
    for (int i = 0; i < LIST_W; i++) if (iso[i]) idx = idx | IDX_W'(i);
    return idx;
  endfunction

  assign w_cnt       = popcount(reg_list);
  assign w_span      = ADDR_WIDTH'(w_cnt) << 2;
  assign w_pend_next = r_pending & (r_pending - LIST_W'(1));

  always_comb begin
    w_state   = r_state;
    w_pending = r_pending;
    w_busy    = r_busy;
    w_valid   = r_valid;
    w_reg_num = r_reg_num;
    w_addr    = r_addr;
    w_first   = r_first;
    w_last    = r_last;
    w_done    = r_done;
    w_wb_addr = r_wb_addr;
    case (r_state)
      S_IDLE: begin
        w_busy  = 1'b0;
        w_valid = 1'b0;
        w_first = 1'b0;
        w_last  = 1'b0;
        w_done  = 1'b0;
        if (start) begin
          w_pending = reg_list;
          w_busy    = 1'b1;
          // Decrementing modes still walk upward, starting from the lowest word.
          case (mode)
            MODE_IA: w_addr = base_addr;
            MODE_IB: w_addr = base_addr + ADDR_WIDTH'(4);
            MODE_DA: w_addr = base_addr - w_span + ADDR_WIDTH'(4);
            default: w_addr = base_addr - w_span;
          endcase
          w_wb_addr = mode[1] ? (base_addr - w_span) : (base_addr + w_span);
          if (reg_list != '0) begin
            w_state   = S_XFER;
            w_valid   = 1'b1;
            w_first   = 1'b1;
            w_reg_num = lowest_idx(reg_list);
            w_last    = (w_cnt == CNT_W'(1));
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
          end
        end
      end
      S_XFER: begin
        if (ready) begin
          w_pending = w_pend_next;
          w_addr    = r_addr + ADDR_WIDTH'(4);
          w_first   = 1'b0;
          if (r_last) begin
            w_state = S_DONE;
            w_valid = 1'b0;
            w_last  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_reg_num = lowest_idx(w_pend_next);
            w_last    = ((w_pend_next & (w_pend_next - LIST_W'(1))) == '0);
          end
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_valid = 1'b0;
        w_done  = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_valid = 1'b0;
        w_first = 1'b0;
        w_last  = 1'b0;
        w_done  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_reg_num <= '0;
      r_addr    <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_wb_addr <= '0;
    end else begin
      r_state   <= w_state;
      r_pending <= w_pending;
      r_busy    <= w_busy;
      r_valid   <= w_valid;
      r_reg_num <= w_reg_num;
      r_addr    <= w_addr;
      r_first   <= w_first;
      r_last    <= w_last;
      r_done    <= w_done;
      r_wb_addr <= w_wb_addr;
    end
  end

  assign busy    = r_busy;
  assign valid   = r_valid;
  assign reg_num = r_reg_num;
  assign addr    = r_addr;
  assign first   = r_first;
  assign last    = r_last;
  assign done    = r_done;
  assign wb_addr = r_wb_addr;

endmodule

// File: tb/tb_register_list_sequencer.sv
// Directed bench for register_list_sequencer with hand-computed transfer sequences.
module tb_register_list_sequencer;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [15:0]   reg_list;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic          ready;
  logic          busy, valid, first, last, done;
  logic [3:0]    reg_num;
  logic [AW-1:0] addr, wb_addr;

  int n_vec = 0;
  int n_err = 0;

  register_list_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .reg_list(reg_list), .mode(mode),
    .base_addr(base_addr), .ready(ready), .busy(busy), .valid(valid),
    .reg_num(reg_num), .addr(addr), .first(first), .last(last), .done(done),
    .wb_addr(wb_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_xfer(input string tag, input logic [3:0] r, input logic [AW-1:0] a,
                          input logic f, input logic l);
    chk({tag, ".valid"}, 64'(valid), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    chk({tag, ".reg_num"}, 64'(reg_num), 64'(r));
    chk({tag, ".addr"}, 64'(addr), 64'(a));
    chk({tag, ".first"}, 64'(first), 64'(f));
    chk({tag, ".last"}, 64'(last), 64'(l));
    chk({tag, ".done"}, 64'(done), 64'd0);
  endtask

  task automatic chk_done(input string tag, input logic [AW-1:0] wb);
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    chk({tag, ".valid"}, 64'(valid), 64'd0);
    chk({tag, ".first"}, 64'(first), 64'd0);
    chk({tag, ".last"}, 64'(last), 64'd0);
    chk({tag, ".wb_addr"}, 64'(wb_addr), 64'(wb));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".valid"}, 64'(valid), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"},
        {8'(busy), 8'(valid), 8'(reg_num), 8'(first), 8'(last), 8'(done), 16'd0}, 64'd0);
    chk({tag, ".addr"}, 64'(addr), 64'd0);
    chk({tag, ".wb_addr"}, 64'(wb_addr), 64'd0);
  endtask

  task automatic do_start(input logic [15:0] l, input logic [1:0] m, input logic [AW-1:0] b);
    reg_list  = l;
    mode      = m;
    base_addr = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; reg_list = '0; mode = '0; base_addr = '0; ready = 1'b1;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_idle("post_reset");

    // IA basic
    do_start(16'h0013, 2'd0, 32'h100);
    chk_xfer("ia0", 4'd0, 32'h100, 1'b1, 1'b0); tick();
    chk_xfer("ia1", 4'd1, 32'h104, 1'b0, 1'b0); tick();
    chk_xfer("ia2", 4'd4, 32'h108, 1'b0, 1'b1); tick();
    chk_done("ia_done", 32'h10C); tick();
    chk_idle("ia_idle");

    // DB full list
    do_start(16'hFFFF, 2'd3, 32'h1000);
    for (int i = 0; i < 16; i++) begin
      chk_xfer($sformatf("db%0d", i), 4'(i), 32'hFC0 + AW'(4 * i), 1'(i == 0), 1'(i == 15));
      tick();
    end
    chk_done("db_done", 32'hFC0); tick();
    chk_idle("db_idle");

    // IB with backpressure
    do_start(16'h8001, 2'd1, 32'h20);
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_xfer($sformatf("ib_hold%0d", k), 4'd0, 32'h24, 1'b1, 1'b0);
      if (k == 3) ready = 1'b1;
      tick();
    end
    chk_xfer("ib1", 4'd15, 32'h28, 1'b0, 1'b1); tick();
    chk_done("ib_done", 32'h28); tick();
    chk_idle("ib_idle");

    // DA empty list
    do_start(16'h0000, 2'd2, 32'h500);
    chk_done("da_empty", 32'h500); tick();
    chk_idle("da_idle");

    // IA wrap-around
    do_start(16'h0003, 2'd0, 32'hFFFF_FFFC);
    chk_xfer("wrap0", 4'd0, 32'hFFFF_FFFC, 1'b1, 1'b0); tick();
    chk_xfer("wrap1", 4'd1, 32'h0000_0000, 1'b0, 1'b1); tick();
    chk_done("wrap_done", 32'h0000_0004); tick();
    chk_idle("wrap_idle");

    // reset after the 2nd transfer of a 5-register list
    do_start(16'h001F, 2'd0, 32'h200);
    chk_xfer("rst0", 4'd0, 32'h200, 1'b1, 1'b0); tick();
    chk_xfer("rst1", 4'd1, 32'h204, 1'b0, 1'b0); tick();
    chk_xfer("rst2", 4'd2, 32'h208, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_async");
    tick();
    reset = 1'b0;
    tick(); tick();
    chk_all_zero("rst_no_resume");

    // new sequence; start pulses while busy and in DONE are ignored
    do_start(16'h0005, 2'd0, 32'h300);
    chk_xfer("re0", 4'd0, 32'h300, 1'b1, 1'b0);
    reg_list = 16'hFFFF; mode = 2'd3; base_addr = 32'h0; start = 1'b1;
    tick();
    chk_xfer("re1", 4'd2, 32'h304, 1'b0, 1'b1); tick();
    chk_done("re_done", 32'h308);
    tick();
    start = 1'b0;
    chk_idle("re_idle0");
    tick();
    chk_idle("re_idle1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
